// File: rtl/csr_btn.sv
//==============================================================================
// csr_btn : CSR-mapped debounced button input with sticky edge flags and IRQ.
// Revision: 1.0
//==============================================================================
`default_nettype none

package csr_btn_pkg;
  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_t;
endpackage

module csr_btn
  import csr_btn_pkg::*;
#(
  parameter logic [11:0] ADDR            = 12'h002,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_enable,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_zimm,
  input  logic [31:0] rs1_data,
  input  csr_op_t     csr_op,
  input  logic        btn,
  output logic [31:0] out,
  output logic        level,
  output logic        irq
);

  localparam int unsigned          c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_s1;
  logic               r_s2;
  logic               r_level;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_rise;
  logic               r_fall;
  logic               r_rise_en;
  logic               r_fall_en;

  logic               w_hit_addr;
  logic               w_hit;
  logic [4:0]         w_reg;
  logic [4:0]         w_src;
  logic [4:0]         w_new;
  logic               w_toggle;
  logic               w_rise_ev;
  logic               w_fall_ev;
  logic               w_unused_hi;

  assign w_hit_addr  = (csr_addr == ADDR);
  assign w_hit       = csr_enable && w_hit_addr;
  assign w_reg       = {r_fall_en, r_rise_en, r_fall, r_rise, r_level};
  assign w_unused_hi = ^rs1_data[31:5];

  // Only the low five bits of the source can affect the register.
  always_comb begin
    w_src = rs1_data[4:0];
    if (csr_op inside {CSRRWI, CSRRSI, CSRRCI}) begin
      w_src = rs1_zimm;
    end
    case (csr_op)
      CSRRS, CSRRSI: w_new = w_reg | w_src;
      CSRRC, CSRRCI: w_new = w_reg & ~w_src;
      default:       w_new = w_src;
    endcase
  end

  assign w_toggle  = (r_s2 != r_level) && (r_cnt == c_CNT_MAX);
  assign w_rise_ev = w_toggle && r_s2;
  assign w_fall_ev = w_toggle && !r_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1      <= RESET_LEVEL;
      r_s2      <= RESET_LEVEL;
      r_level   <= RESET_LEVEL;
      r_cnt     <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_rise_en <= 1'b0;
      r_fall_en <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;

      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (w_hit) begin
        r_rise_en <= w_new[3];
        r_fall_en <= w_new[4];
      end

      // Software may only clear a flag; a same-edge hardware event wins.
      r_rise <= w_rise_ev || (r_rise && (!w_hit || w_new[1]));
      r_fall <= w_fall_ev || (r_fall && (!w_hit || w_new[2]));
    end
  end

  assign out   = (w_hit_addr && !reset) ? {27'b0, w_reg} : 32'b0;
  assign level = r_level;
  assign irq   = (r_rise && r_rise_en) || (r_fall && r_fall_en);

endmodule

`default_nettype wire

// File: tb/tb_csr_btn.sv
//==============================================================================
// tb_csr_btn : self-checking bench for csr_btn (vector table, corners, random).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_csr_btn;
  import csr_btn_pkg::*;

  localparam int          D = 4;
  localparam logic [11:0] A = 12'h002;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_enable;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_zimm;
  logic [31:0] rs1_data;
  csr_op_t     csr_op;
  logic        btn;
  logic [31:0] out;
  logic        level;
  logic        irq;

  always #5 clk = ~clk;

  csr_btn #(
    .ADDR(A),
    .DEBOUNCE_CYCLES(D),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .csr_enable(csr_enable),
    .csr_addr(csr_addr),
    .rs1_zimm(rs1_zimm),
    .rs1_data(rs1_data),
    .csr_op(csr_op),
    .btn(btn),
    .out(out),
    .level(level),
    .irq(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the level flips once the last D synchronized samples
  // all disagree with it; the synchronizer is a two-deep delay line.
  bit m_level, m_rise, m_fall, m_ren, m_fen;
  bit m_sync[$];
  bit m_win[$];

  function automatic logic [4:0] m_reg();
    return {m_fen, m_ren, m_fall, m_rise, m_level};
  endfunction

  function automatic void model_reset();
    m_level = 0; m_rise = 0; m_fall = 0; m_ren = 0; m_fen = 0;
    m_sync = '{1'b0, 1'b0};
    m_win.delete();
  endfunction

  function automatic void model_edge(input logic en, input logic [11:0] addr, input csr_op_t op,
                                     input logic [4:0] zimm, input logic [31:0] data, input logic b);
    bit ev_r = 0, ev_f = 0, all_diff = 1;
    logic [4:0] src, nv, old;
    old = m_reg();
    m_win.push_back(m_sync[1]);
    if (m_win.size() > D) void'(m_win.pop_front());
    foreach (m_win[k]) if (m_win[k] == m_level) all_diff = 0;
    if (m_win.size() == D && all_diff) begin
      if (m_level) ev_f = 1; else ev_r = 1;
      m_level = !m_level;
      m_win.delete();
    end
    src = (op == CSRRWI || op == CSRRSI || op == CSRRCI) ? zimm : data[4:0];
    if (op == CSRRS || op == CSRRSI)      nv = old | src;
    else if (op == CSRRC || op == CSRRCI) nv = old & ~src;
    else                                  nv = src;
    if (en && addr == A) begin
      m_ren  = nv[3];
      m_fen  = nv[4];
      m_rise = m_rise & nv[1];
      m_fall = m_fall & nv[2];
    end
    m_rise = m_rise | ev_r;
    m_fall = m_fall | ev_f;
    m_sync[1] = m_sync[0];
    m_sync[0] = b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against model, then take the edge.
  task automatic step(input logic en, input logic [11:0] addr, input csr_op_t op,
                      input logic [4:0] zimm, input logic [31:0] data, input logic b,
                      output logic [31:0] o_out, output logic o_lvl, output logic o_irq);
    @(negedge clk);
    csr_enable = en; csr_addr = addr; csr_op = op;
    rs1_zimm = zimm; rs1_data = data; btn = b;
    #1;
    check("model_out", out, (addr == A) ? {27'b0, m_reg()} : 32'b0);
    check("model_level", {31'b0, level}, {31'b0, m_level});
    check("model_irq", {31'b0, irq}, {31'b0, (m_rise & m_ren) | (m_fall & m_fen)});
    o_out = out; o_lvl = level; o_irq = irq;
    @(posedge clk);
    model_edge(en, addr, op, zimm, data, b);
  endtask

  task automatic count_rise(input string name);
    logic [31:0] o; logic l, q;
    int found = -1;
    for (int j = 0; j < 20 && found < 0; j++) begin
      step(1'b0, A, CSRRS, 5'd0, 32'd0, 1'b1, o, l, q);
      if (l) found = j;
    end
    check(name, found, D + 2);
  endtask

  typedef struct {
    logic        en;
    logic [11:0] addr;
    csr_op_t     op;
    logic [4:0]  zimm;
    logic [31:0] data;
    logic        b;
    logic [31:0] e_out;
    logic        e_lvl;
    logic        e_irq;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [11:0] addr, input csr_op_t op,
                              input logic [4:0] zimm, input logic b,
                              input logic [31:0] e_out, input logic e_lvl, input logic e_irq);
    vec_t v;
    v.en = en; v.addr = addr; v.op = op; v.zimm = zimm; v.data = 32'd0; v.b = b;
    v.e_out = e_out; v.e_lvl = e_lvl; v.e_irq = e_irq;
    return v;
  endfunction

  vec_t tbl[23];
  csr_op_t ops[6] = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o; logic l, q; logic rb;

    // Rise after D+2 edges, enable/clear via immediates, fall with irq.
    for (int i = 0; i < 6; i++) tbl[i] = mk(0, A, CSRRS, 0, 1, 32'h00, 0, 0);
    tbl[6]  = mk(1, A,      CSRRS,  5'h00, 1, 32'h03, 1, 0);
    tbl[7]  = mk(1, A,      CSRRSI, 5'h08, 1, 32'h03, 1, 0);
    tbl[8]  = mk(0, A,      CSRRS,  5'h00, 1, 32'h0B, 1, 1);
    tbl[9]  = mk(1, A,      CSRRCI, 5'h02, 1, 32'h0B, 1, 1);
    tbl[10] = mk(0, A,      CSRRS,  5'h00, 1, 32'h09, 1, 0);
    tbl[11] = mk(1, A,      CSRRWI, 5'h1F, 1, 32'h09, 1, 0);
    tbl[12] = mk(0, A,      CSRRS,  5'h00, 1, 32'h19, 1, 0);
    tbl[13] = mk(1, 12'h003, CSRRW, 5'h00, 1, 32'h00, 1, 0);
    for (int i = 14; i < 20; i++) tbl[i] = mk(0, A, CSRRS, 0, 0, 32'h19, 1, 0);
    tbl[20] = mk(0, A,      CSRRS,  5'h00, 0, 32'h1C, 0, 1);
    tbl[21] = mk(1, A,      CSRRW,  5'h00, 0, 32'h1C, 0, 1);
    tbl[22] = mk(0, A,      CSRRS,  5'h00, 0, 32'h00, 0, 0);

    reset = 1'b1; csr_enable = 0; csr_addr = A; csr_op = CSRRS;
    rs1_zimm = 0; rs1_data = 0; btn = 0;
    model_reset();
    #1;
    check("reset_out", out, 32'h0);
    check("reset_level", {31'b0, level}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].addr, tbl[i].op, tbl[i].zimm, tbl[i].data, tbl[i].b, o, l, q);
      check($sformatf("tbl%0d_out", i), o, tbl[i].e_out);
      check($sformatf("tbl%0d_level", i), {31'b0, l}, {31'b0, tbl[i].e_lvl});
      check($sformatf("tbl%0d_irq", i), {31'b0, q}, {31'b0, tbl[i].e_irq});
    end

    // Short pulse is filtered, and the next clean step still takes D+2 edges.
    for (int j = 0; j < 11; j++) begin
      step(0, A, CSRRS, 0, 0, (j < 3), o, l, q);
      check("pulse_out", o, 32'h0);
    end
    count_rise("pulse_then_step_edges");

    // Software clear of RISE on the very edge the level rises.
    step(1, A, CSRRW, 0, 0, 1, o, l, q);
    for (int j = 0; j < D + 4; j++) step(0, A, CSRRS, 0, 0, 0, o, l, q);
    step(1, A, CSRRW, 0, 0, 0, o, l, q);
    for (int j = 0; j < 8; j++) begin
      step((j == 5), A, CSRRC, 0, 32'h2, 1, o, l, q);
      if (j == 6) check("rise_collide", o & 32'h3, 32'h3);
    end

    // Asynchronous reset mid-count with RISE and RISE_EN set.
    step(1, A, CSRRSI, 5'h08, 0, 1, o, l, q);
    step(0, A, CSRRS, 0, 0, 0, o, l, q);
    step(0, A, CSRRS, 0, 0, 0, o, l, q);
    @(negedge clk);
    csr_enable = 0; csr_addr = A; btn = 1;
    #1;
    check("irq_pre_reset", {31'b0, irq}, 32'h1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_out", out, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    check("async_rst_level", {31'b0, level}, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    count_rise("post_reset_rise_edges");

    // Randomized traffic against the model.
    rb = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      step($urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? 12'($urandom) : A,
           ops[$urandom_range(0, 5)],
           5'($urandom), $urandom, rb, o, l, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
